// File: rtl/select_biggest_way_pkg.sv
// ---------------------------------------------------------------------------
// select_biggest_way_pkg
//   Default widths and elaboration-time helpers for the masked maximum tree.
//   The helpers describe the tree shape for any number of ways (including
//   non powers of two):
//     index_width(n)      : width needed to hold a way number, at least 1
//     num_levels(n)       : tree depth, ceil(log2(n)), 0 for a single way
//     level_size(n, l)    : number of nodes at level l (level 0 = leaves)
//     level_offset(n, l)  : position of level l's first node in the flat
//                           node storage (levels stored back to back)
//     total_nodes(n)      : number of nodes in the whole tree
// ---------------------------------------------------------------------------
package select_biggest_way_pkg;

    localparam int DEFAULT_WAY_WIDTH = 4;
    localparam int DEFAULT_NUM_WAY   = 16;

    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int num_levels(input int n);
        int s;
        int lv;
        s  = n;
        lv = 0;
        for (int k = 0; k < 32; k++) begin
            if (s > 1) begin
                s  = (s + 1) / 2;
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

    // Each level halves the previous one, rounding up so an odd node is kept.
    function automatic int level_size(input int n, input int l);
        int s;
        s = n;
        for (int k = 0; k < l; k++) begin
            s = (s + 1) / 2;
        end
        return s;
    endfunction

    function automatic int level_offset(input int n, input int l);
        int off;
        off = 0;
        for (int k = 0; k < l; k++) begin
            off = off + level_size(n, k);
        end
        return off;
    endfunction

    function automatic int total_nodes(input int n);
        return level_offset(n, num_levels(n) + 1);
    endfunction

endpackage

// File: rtl/select_biggest_way_node.sv
// ---------------------------------------------------------------------------
// select_biggest_node
//   One combinational node of the maximum tree. Merges two (valid, value,
//   index) candidates into one.
//   Ports:
//     a_valid_i/a_value_i/a_index_i : left candidate (covers lower way numbers)
//     b_valid_i/b_value_i/b_index_i : right candidate (covers higher way numbers)
//     y_valid_o/y_value_o/y_index_o : winning candidate
// ---------------------------------------------------------------------------
module select_biggest_node #(
    parameter int VALUE_WIDTH = 4,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   a_valid_i,
    input  logic [VALUE_WIDTH-1:0] a_value_i,
    input  logic [INDEX_WIDTH-1:0] a_index_i,
    input  logic                   b_valid_i,
    input  logic [VALUE_WIDTH-1:0] b_value_i,
    input  logic [INDEX_WIDTH-1:0] b_index_i,
    output logic                   y_valid_o,
    output logic [VALUE_WIDTH-1:0] y_value_o,
    output logic [INDEX_WIDTH-1:0] y_index_o
);

    logic take_b;

    // Right side wins only when it is valid and either the left side is
    // invalid or the right value is strictly larger. Equal values keep the
    // left (lower-numbered) way, which gives the lowest-index tie rule.
    // The valid terms are evaluated first so an invalid side's value never
    // decides the outcome.
    assign take_b    = b_valid_i & (~a_valid_i | (b_value_i > a_value_i));

    assign y_valid_o = a_valid_i | b_valid_i;
    assign y_value_o = take_b ? b_value_i : a_value_i;
    assign y_index_o = take_b ? b_index_i : a_index_i;

endmodule

// File: rtl/select_biggest_way.sv
// ---------------------------------------------------------------------------
// select_biggest_way
//   Masked maximum selector: returns the largest value among the ways whose
//   condition bit is set, the number of that way, and a valid flag. All
//   outputs are registered, one cycle after the inputs are sampled.
//   No handshake: a new input set is accepted on every rising edge and its
//   result is presented after that edge; the block never stalls.
//   Ports:
//     clk_in           : clock, rising edge
//     reset_in         : asynchronous active-low reset
//     way_flatted_in   : NUM_WAY packed values, way i at [i*W +: W]
//     condition_in     : per-way eligibility mask
//     select_out       : largest eligible value (0 when none eligible)
//     select_index_out : way number of select_out (0 when none eligible)
//     select_valid_out : at least one way was eligible
// ---------------------------------------------------------------------------
module select_biggest_way
    import select_biggest_way_pkg::*;
#(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = DEFAULT_WAY_WIDTH,
    parameter int NUM_WAY                  = DEFAULT_NUM_WAY,
    localparam int INDEX_WIDTH             = index_width(NUM_WAY)
) (
    input  logic                                        clk_in,
    input  logic                                        reset_in,
    input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_in,
    input  logic [NUM_WAY-1:0]                          condition_in,
    output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         select_out,
    output logic [INDEX_WIDTH-1:0]                      select_index_out,
    output logic                                        select_valid_out
);

    localparam int W      = SINGLE_WAY_WIDTH_IN_BITS;
    localparam int IW     = INDEX_WIDTH;
    localparam int LEVELS = num_levels(NUM_WAY);
    localparam int TOTAL  = total_nodes(NUM_WAY);
    localparam int ROOT   = TOTAL - 1;

    // Flat node storage: leaves first, then each tree level, root last.
    logic [TOTAL-1:0] node_valid;
    logic [W-1:0]     node_value [TOTAL];
    logic [IW-1:0]    node_index [TOTAL];

    // Leaves. Ineligible values are forced to 0 so nothing unknown on an
    // ineligible way can reach the comparators; the valid bit still keeps
    // them out of the comparison entirely.
    for (genvar i = 0; i < NUM_WAY; i++) begin : gen_leaf
        assign node_valid[i] = condition_in[i];
        assign node_value[i] = condition_in[i] ? way_flatted_in[i*W +: W] : '0;
        assign node_index[i] = IW'(i);
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : gen_level
        localparam int PREV_N   = level_size(NUM_WAY, l - 1);
        localparam int PREV_OFF = level_offset(NUM_WAY, l - 1);
        localparam int CUR_N    = level_size(NUM_WAY, l);
        localparam int CUR_OFF  = level_offset(NUM_WAY, l);

        for (genvar j = 0; j < CUR_N; j++) begin : gen_node
            if (2 * j + 1 < PREV_N) begin : gen_pair
                select_biggest_node #(
                    .VALUE_WIDTH (W),
                    .INDEX_WIDTH (IW)
                ) u_node (
                    .a_valid_i (node_valid[PREV_OFF + 2*j]),
                    .a_value_i (node_value[PREV_OFF + 2*j]),
                    .a_index_i (node_index[PREV_OFF + 2*j]),
                    .b_valid_i (node_valid[PREV_OFF + 2*j + 1]),
                    .b_value_i (node_value[PREV_OFF + 2*j + 1]),
                    .b_index_i (node_index[PREV_OFF + 2*j + 1]),
                    .y_valid_o (node_valid[CUR_OFF + j]),
                    .y_value_o (node_value[CUR_OFF + j]),
                    .y_index_o (node_index[CUR_OFF + j])
                );
            end else begin : gen_pass
                // Odd node count: the last node has no partner this level.
                assign node_valid[CUR_OFF + j] = node_valid[PREV_OFF + 2*j];
                assign node_value[CUR_OFF + j] = node_value[PREV_OFF + 2*j];
                assign node_index[CUR_OFF + j] = node_index[PREV_OFF + 2*j];
            end
        end
    end

    logic [W-1:0]  select_d,       select_q;
    logic [IW-1:0] select_index_d, select_index_q;
    logic          select_valid_d, select_valid_q;

    // With nothing eligible the outputs read as all zero.
    always_comb begin
        select_d       = '0;
        select_index_d = '0;
        select_valid_d = node_valid[ROOT];
        if (node_valid[ROOT]) begin
            select_d       = node_value[ROOT];
            select_index_d = node_index[ROOT];
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            select_q       <= '0;
            select_index_q <= '0;
            select_valid_q <= 1'b0;
        end else begin
            select_q       <= select_d;
            select_index_q <= select_index_d;
            select_valid_q <= select_valid_d;
        end
    end

    assign select_out       = select_q;
    assign select_index_out = select_index_q;
    assign select_valid_out = select_valid_q;

endmodule

// File: tb/tb_select_biggest_way.sv
module tb_select_biggest_way;

    localparam int W  = 4;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int EW = 1 + IW + W;   // {valid, index, value}

    typedef struct {
        logic [W*N-1:0] ways;
        logic [N-1:0]   cond;
        logic [W-1:0]   exp_val;
        logic [IW-1:0]  exp_idx;
        logic           exp_vld;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_in;
    logic [W*N-1:0] way_flatted_in;
    logic [N-1:0]   condition_in;
    logic [W-1:0]   select_out;
    logic [IW-1:0]  select_index_out;
    logic           select_valid_out;

    select_biggest_way #(
        .SINGLE_WAY_WIDTH_IN_BITS (W),
        .NUM_WAY                  (N)
    ) dut (
        .clk_in           (clk),
        .reset_in         (reset_in),
        .way_flatted_in   (way_flatted_in),
        .condition_in     (condition_in),
        .select_out       (select_out),
        .select_index_out (select_index_out),
        .select_valid_out (select_valid_out)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];

    // Reference: linear scan, strictly-greater update keeps the lowest index.
    function automatic logic [EW-1:0] model(input logic [W*N-1:0] ways, input logic [N-1:0] cond);
        logic          found;
        logic [W-1:0]  best;
        logic [IW-1:0] bi;
        found = 1'b0;
        best  = '0;
        bi    = '0;
        for (int i = 0; i < N; i++) begin
            if (cond[i] && (!found || ways[i*W +: W] > best)) begin
                found = 1'b1;
                best  = ways[i*W +: W];
                bi    = IW'(i);
            end
        end
        return {found, bi, best};
    endfunction

    task automatic compare(input string name, input logic [EW-1:0] exp);
        total++;
        if (select_out !== exp[W-1:0]) begin
            bad++;
            $display("FAIL %s.value got=%h want=%h t=%0t", name, select_out, exp[W-1:0], $time);
        end
        total++;
        if (select_index_out !== exp[W+IW-1:W]) begin
            bad++;
            $display("FAIL %s.index got=%0d want=%0d t=%0t", name, select_index_out, exp[W+IW-1:W], $time);
        end
        total++;
        if (select_valid_out !== exp[EW-1]) begin
            bad++;
            $display("FAIL %s.valid got=%b want=%b t=%0t", name, select_valid_out, exp[EW-1], $time);
        end
    endtask

    task automatic check_pending(input string name);
        if (exp_q.size() > 0) compare(name, exp_q.pop_front());
    endtask

    // ---------------- driver ----------------
    // Each call checks the result of the previous cycle's inputs, then drives new ones.
    task automatic tick(input string name, input logic [W*N-1:0] ways, input logic [N-1:0] cond,
                        input logic [EW-1:0] exp);
        @(negedge clk);
        check_pending(name);
        way_flatted_in = ways;
        condition_in   = cond;
        exp_q.push_back(exp);
    endtask

    task automatic flush(input string name);
        @(negedge clk);
        check_pending(name);
    endtask

    vec_t vecs[8];

    initial begin
        logic [W*N-1:0] rw;
        logic [N-1:0]   rc;
        logic [W*N-1:0] v1;

        reset_in       = 1'b0;
        way_flatted_in = 64'hFEDC_BA98_7654_3210;
        condition_in   = '1;

        vecs[0] = '{64'hABCD_5234_5234_ABA5, 16'b1110_0111_1110_0111, 4'hC, 4'd13, 1'b1};
        vecs[1] = '{64'h587C_2934_2934_587A, 16'b1011_0111_1111_1111, 4'hC, 4'd12, 1'b1};
        vecs[2] = '{64'h1111_11F1_1111_F111, 16'hFFFF,                4'hF, 4'd3,  1'b1};
        vecs[3] = '{64'hFEDC_BA98_7654_3210, 16'h0000,                4'h0, 4'd0,  1'b0};
        vecs[4] = '{64'hFFFF_FFFF_0FFF_FFFF, 16'h0080,                4'h0, 4'd7,  1'b1};
        vecs[5] = '{64'hF333_3333_3333_3333, 16'hFFFF,                4'hF, 4'd15, 1'b1};
        vecs[6] = '{64'h1234_5678_9ABC_D12E, 16'hFFFF,                4'hE, 4'd0,  1'b1};
        vecs[7] = '{64'h0000_0000_0000_0000, 16'hFFFF,                4'h0, 4'd0,  1'b1};

        // Outputs held at zero while reset is low, even across clock edges.
        @(posedge clk);
        #2;
        compare("reset", '0);

        @(negedge clk);
        reset_in = 1'b1;

        // Table vectors, back to back on consecutive cycles.
        foreach (vecs[k]) begin
            tick($sformatf("vec%0d", k), vecs[k].ways, vecs[k].cond,
                 {vecs[k].exp_vld, vecs[k].exp_idx, vecs[k].exp_val});
        end
        flush("vec_last");

        // Random vectors; narrow value ranges on half of them to force ties.
        for (int r = 0; r < 60; r++) begin
            for (int n = 0; n < N; n++) begin
                rw[n*W +: W] = (r % 2 == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 2));
            end
            case (r % 4)
                0:       rc = N'(1) << $urandom_range(0, N - 1);
                1:       rc = '1;
                default: rc = N'($urandom_range(0, 16'hFFFF));
            endcase
            tick("rand", rw, rc, model(rw, rc));
        end
        flush("rand_last");

        // Ineligible ways carrying unknowns must not disturb the result.
        rw = {N*W{1'bx}};
        rw[5*W +: W] = 4'h6;
        rw[6*W +: W] = 4'h9;
        rw[7*W +: W] = 4'h9;
        tick("x_ineligible", rw, 16'h00E0, {1'b1, 4'd6, 4'h9});
        tick("single_way15", 64'h0FFF_FFFF_FFFF_FFFF, 16'h8000, {1'b1, 4'd15, 4'h0});
        flush("single_way15");

        // Asynchronous reset mid-stream.
        v1 = 64'h0000_0000_0000_00A0;
        tick("pre_rst_drive", v1, 16'h0002, {1'b1, 4'd1, 4'hA});
        @(posedge clk);
        #1;
        check_pending("pre_rst");
        #2;
        reset_in = 1'b0;
        #1;
        compare("async_rst", '0);
        @(posedge clk);
        #1;
        compare("rst_hold", '0);

        // Release with a new input set; result appears after the next edge.
        @(negedge clk);
        reset_in       = 1'b1;
        way_flatted_in = 64'h0000_0000_0000_7000;
        condition_in   = 16'hFFFF;
        exp_q.push_back({1'b1, 4'd3, 4'h7});
        flush("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/select_biggest_way.md
Name: select_biggest_way

Overview:
- Masked maximum selector. Takes NUM_WAY packed unsigned values and a per-way enable mask, and returns the largest value among the enabled ways.
- Also returns the index of the winning way and a valid flag. All outputs are registered.
- Used by replacement and priority logic to pick the way with the highest score among eligible candidates.

Parameters:
SINGLE_WAY_WIDTH_IN_BITS, 4, width of each way's unsigned value
NUM_WAY, 16, number of ways; any value >= 1 (need not be a power of two)
INDEX_WIDTH, $clog2(NUM_WAY) with a minimum of 1, width of the index output (derived)

Ports:
clk_in  input  1  clock; all state updates on the rising edge
reset_in  input  1  asynchronous, active-low reset
way_flatted_in  input  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY  packed values; way i occupies bits [i*W +: W], way 0 in the LSBs
condition_in  input  NUM_WAY  bit i = 1 makes way i eligible
select_out  output  SINGLE_WAY_WIDTH_IN_BITS  largest eligible value
select_index_out  output  INDEX_WIDTH  way number holding select_out
select_valid_out  output  1  1 when at least one condition_in bit was set

Behaviour:
- Reset (reset_in = 0, asynchronous assert): select_out = 0, select_index_out = 0, select_valid_out = 0. Held at these values while reset_in is low.
- Release of reset is synchronous to clk_in; the first computed result appears after the first rising edge following release.
- Compute path is purely combinational from way_flatted_in and condition_in to the output registers:
  - Ineligible ways are excluded from comparison. They are not treated as 0.
  - Compare as unsigned.
  - select_out = maximum over eligible ways.
  - select_index_out = that way's number.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N.
- Throughput: a new input set every cycle. No handshake, no stall.
- Tie rule: when several eligible ways share the maximum value, the lowest way index wins.
- No eligible way (condition_in = 0): select_out = 0, select_index_out = 0, select_valid_out = 0.
- Single eligible way: that way's value and index are output, even when the value is 0. select_valid_out = 1.
- All ways eligible: the global maximum is output.
- Value 0 on an eligible way is a legal candidate. It wins only if every eligible way holds 0, in which case the lowest eligible index is output.
- Structure: balanced binary comparison tree of depth ceil(log2(NUM_WAY)). Each node carries (valid, value, index).
  - Node rule: if only one child is valid, take that child.
  - If both children are valid, take the right child only when its value is strictly greater than the left child's value; otherwise take the left child.
  - The left child always covers the lower indices, which enforces the tie rule.
  - With an odd number of nodes at a level, the unpaired node passes through unchanged.
- X on inputs of ineligible ways must not affect the outputs.

Decomposition:
- Package: no shared typedefs. Widths are parameter-derived locally; INDEX_WIDTH is computed in the module.
- One sub-module: select_biggest_node.
  - Two (valid, value, index) candidates in, one out.
  - Combinational, parameterised by value width and index width.
  - Instantiated in a generate loop to build the tree.
- The top level holds the tree and the output registers only.

Test Plan:
- Way values 15..0 = a,b,c,d,5,2,3,4,5,2,3,4,a,b,a,5; condition = 16'b1110_0111_1110_0111 -> one cycle later select_out = c, select_index_out = 13, valid = 1. The ineligible d at way 12 is ignored.
- Way values 15..0 = 5,8,7,c,2,9,3,4,2,9,3,4,5,8,7,a; condition = 16'b1011_0111_1111_1111 -> select_out = c, index = 12, valid = 1.
- Tie: ways 3 and 9 both = f, all others 1, condition all 1 -> select_out = f, index = 3.
- condition = 0 with arbitrary values -> select_out = 0, index = 0, valid = 0. Only bit 7 set with way 7 = 0 -> select_out = 0, index = 7, valid = 1.
- Back-to-back inputs on consecutive cycles -> each result appears exactly one cycle after its inputs, with no gaps. Max at way 15 (f), then at way 0 (e), both resolved correctly.
- Assert reset_in low mid-stream, asynchronous to the clock -> outputs clear immediately to 0/0/0. After release, the first result appears one cycle after the next edge.
